countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counter with a start/busy/done handshake. It is the terminating end of the multi-cycle timing path: the requester loads an iteration count, and the block signals when that count has elapsed.
- Used by the multdiv control, and by other multi-cycle units, to track remaining iterations. This replaces free-running up-count comparison.
- All outputs are registered. Single clock domain.

Parameters:
- WIDTH, 6, width of load_value and count. Maximum single run is 2^WIDTH-1 = 63 cycles.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new countdown; sampled on the rising edge
- load_value  input  WIDTH  number of cycles to count; sampled with start
- pause  input  1  hold count in RUN; no decrement while high
- cancel  input  1  abort a run in progress; no done is produced
- count  output  WIDTH  cycles remaining
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (sync, active-high) has priority over all other inputs:
  - state=IDLE, count=0, busy=0, done=0, internal reload register=0.
  - Reset asserted mid-run aborts the run with no done pulse.
- States: IDLE, RUN, DONE. busy=1 only in RUN. done=1 only in DONE.
- IDLE:
  - start=1 with load_value=N, N!=0: count<=N, reload register<=N, go to RUN.
  - start=1 with load_value=0: count stays 0, go to DONE (zero-length run, done after 1 edge, busy never asserted).
  - start=0: stay in IDLE, count holds.
  - pause and cancel are ignored in IDLE.
- RUN, in priority order:
  1. cancel=1: go to IDLE, count<=0, no done pulse. start in the same cycle is ignored.
  2. pause=1: count holds, stay in RUN.
  3. count>1: count<=count-1.
  4. count==1: count<=0, go to DONE.
  - start is ignored while in RUN; load_value is not re-sampled.
- DONE:
  - done=1 for exactly one cycle, count=0.
  - start=1 here is accepted exactly as in IDLE, which gives back-to-back runs with no idle gap.
  - Otherwise go to IDLE.
- Latency:
  - start is sampled at edge E0 with N>0 and no pause.
  - busy=1 after edges E0 through E(N-1), i.e. N cycles.
  - done=1 in the cycle after edge EN.
  - Each paused RUN cycle extends this by one.
- Width rules:
  - Decrement is WIDTH-bit unsigned and never wraps below 0, because the RUN exit occurs at count==1.
  - load_value = all-ones (63) is legal.

Optional Feature:
- Macro: COUNTDOWN_AUTORELOAD_EN
- Defined:
  - In RUN, count==1 with no pause gives count<=reload register, state stays RUN, busy stays 1, and done pulses for that one cycle.
  - The result is a periodic done every N unpaused cycles.
  - cancel or reset is the only exit.
  - A start with load_value=0 still behaves as a single zero-length run.
- Undefined:
  - Single-shot behaviour as above; the reload register may be omitted.

Test Plan:
- Reset, then start with load_value=5 -> busy high 5 cycles, count 5,4,3,2,1, then count=0, busy=0, done=1 for 1 cycle, then IDLE.
- load_value=3 with pause high for 2 cycles mid-run -> count holds during pause; done arrives 5 edges after start; exactly one done pulse.
- load_value=10, cancel asserted when count=6 -> next cycle IDLE, count=0, busy=0; done never asserted.
- load_value=0 -> busy stays 0; done=1 one cycle after start.
- Back-to-back: start with N=2, then start with N=4 held during the DONE cycle -> second run begins immediately, count=4 the cycle after done.
- Reset asserted in RUN at count=20 -> next cycle all outputs 0. With COUNTDOWN_AUTORELOAD_EN and N=3: done pulses every 3 cycles, busy stays high, count sequence 3,2,1,3,2,1…

Source files
------------

// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - requester/timer handshake bundle for countdown_timer
interface countdown_timer_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic [WIDTH-1:0] load_value;
    logic             pause;
    logic             cancel;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    // Requester side: issues start/pause/cancel and watches progress.
    modport master (
        output start, load_value, pause, cancel,
        input  count, busy, done
    );

    // Timer side: consumes requests and reports progress.
    modport slave (
        input  start, load_value, pause, cancel,
        output count, busy, done
    );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with start/busy/done handshake; optional periodic mode via COUNTDOWN_AUTORELOAD_EN
module countdown_timer #(
    parameter int WIDTH = 6
) (
    input  logic              clock,
    input  logic              reset,
    countdown_timer_if.slave  tif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    // Next-state and next-output decode; done is a registered pulse so it can
    // coincide with RUN when the periodic mode reloads the counter.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        done_d   = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (tif.start) begin
                    if (tif.load_value != '0) begin
                        state_d  = RUN;
                        count_d  = tif.load_value;
`ifdef COUNTDOWN_AUTORELOAD_EN
                        reload_d = tif.load_value;
`endif
                    end else begin
                        // Zero-length run: completes on the very next edge.
                        state_d = DONE;
                        count_d = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (tif.cancel) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (tif.pause) begin
                    count_d = count_q;
                end else if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    // Exit at one rather than zero so the decrement never wraps.
                    done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    count_d = reload_q;
`else
                    state_d = DONE;
                    count_d = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // State, counter and pulse registers; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            done_q   <= done_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign tif.count = count_q;
    assign tif.busy  = (state_q == RUN);
    assign tif.done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed and randomized checks of countdown_timer against a cycle-count model
module tb_countdown_timer;

    localparam int WIDTH = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;

    countdown_timer_if #(.WIDTH(WIDTH)) tif ();

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .tif   (tif.slave)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference: cycles still to run (0 = not running), reload amount, pulse.
    int m_rem    = 0;
    int m_reload = 0;
    bit m_done   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit s, input int lv, input bit p, input bit c, input bit r);
        if (r) begin
            m_rem = 0; m_reload = 0; m_done = 1'b0;
        end else if (m_rem > 0) begin
            m_done = 1'b0;
            if (c) m_rem = 0;
            else if (!p) begin
                if (m_rem > 1) m_rem = m_rem - 1;
                else begin
                    m_done = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    m_rem = m_reload;
`else
                    m_rem = 0;
`endif
                end
            end
        end else begin
            m_done = 1'b0;
            if (s) begin
                if (lv > 0) begin m_rem = lv; m_reload = lv; end
                else m_done = 1'b1;
            end
        end
    endtask

    task automatic step(input bit s, input int lv, input bit p, input bit c, input bit r);
        tif.start      = s;
        tif.load_value = lv[WIDTH-1:0];
        tif.pause      = p;
        tif.cancel     = c;
        reset          = r;
        @(posedge clock);
        model(s, lv, p, c, r);
        #1;
        chk("count", 32'(tif.count), 32'(m_rem));
        chk("busy",  32'(tif.busy),  32'(m_rem > 0));
        chk("done",  32'(tif.done),  32'(m_done));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        tif.start = 1'b0; tif.load_value = '0; tif.pause = 1'b0; tif.cancel = 1'b0;

        // Reset state
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("reset_count", 32'(tif.count), 0);

        // N=5: count 5..1 with busy, then a single done
        step(1, 5, 0, 0, 0);
        chk("n5_first", 32'(tif.count), 5);
        idle(4);
        chk("n5_last", 32'(tif.count), 1);
        idle(1);
        chk("n5_done", 32'(tif.done), 1);
        chk("n5_busy_off", 32'(tif.busy), 0);
        idle(2);

        // N=3 with two paused cycles: done five edges after start
        step(1, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("pause_hold", 32'(tif.count), 2);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("pause_done", 32'(tif.done), 1);
        idle(2);

        // N=10 cancelled at count 6
        step(1, 10, 0, 0, 0);
        idle(4);
        chk("cancel_at6", 32'(tif.count), 6);
        step(0, 0, 0, 1, 0);
        chk("cancel_busy", 32'(tif.busy), 0);
        idle(2);

        // Zero-length run
        step(1, 0, 0, 0, 0);
        chk("zero_done", 32'(tif.done), 1);
        idle(2);

        // Back-to-back: N=2, then N=4 started in the done cycle
        step(1, 2, 0, 0, 0);
        idle(2);
        chk("b2b_done", 32'(tif.done), 1);
        step(1, 4, 0, 0, 0);
        chk("b2b_reload", 32'(tif.count), 4);
        idle(5);

        // Reset mid-run at count 20
        step(1, 30, 0, 0, 0);
        idle(10);
        chk("rst_at20", 32'(tif.count), 20);
        step(0, 0, 0, 0, 1);
        chk("rst_busy", 32'(tif.busy), 0);

        // Maximum load value
        step(1, 63, 0, 0, 0);
        chk("max_load", 32'(tif.count), 63);
        idle(64);
        step(0, 0, 0, 1, 0);

`ifdef COUNTDOWN_AUTORELOAD_EN
        // Periodic mode: 3,2,1,3,2,1 with done alongside each reload
        step(1, 3, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0);
        chk("auto_reload", 32'(tif.count), 3);
        chk("auto_done", 32'(tif.done), 1);
        idle(6);
        step(0, 0, 0, 1, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel, lv;
            sel = $urandom_range(0, 7);
            lv  = (sel == 0) ? 0 : (sel == 1) ? 63 : $urandom_range(1, 8);
            step($urandom_range(0, 3) == 0, lv, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
